// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline boundary registers: payload widths,
// field packing offsets and the reset payloads derived from PC_INIT.
package pipe_stage_reg_pkg;

    // Reset vector of the core; every boundary comes out of reset pointing here.
    localparam logic [31:0] PC_INIT = 32'hBFC0_0000;

    // Canonical no-op instruction (addi x0, x0, 0) used to fill empty slots.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // ID/EXE payload: {pc, instr, rd}
    localparam int unsigned ID_EXE_RD_LSB    = 0;
    localparam int unsigned ID_EXE_INSTR_LSB = 5;
    localparam int unsigned ID_EXE_PC_LSB    = 37;
    localparam int unsigned ID_EXE_W         = 69;

    // EXE/MEM payload: {pc, alu_result, rd}
    localparam int unsigned EXE_MEM_RD_LSB  = 0;
    localparam int unsigned EXE_MEM_ALU_LSB = 5;
    localparam int unsigned EXE_MEM_PC_LSB  = 37;
    localparam int unsigned EXE_MEM_W       = 69;

    // MEM/WB payload: {wb_data, rd, wb_en}
    localparam int unsigned MEM_WB_WE_LSB   = 0;
    localparam int unsigned MEM_WB_RD_LSB   = 1;
    localparam int unsigned MEM_WB_DATA_LSB = 6;
    localparam int unsigned MEM_WB_W        = 38;

    // Reset payloads per boundary.
    localparam logic [ID_EXE_W-1:0]  ID_EXE_RST  = {PC_INIT, NOP_INSTR, 5'd0};
    localparam logic [EXE_MEM_W-1:0] EXE_MEM_RST = {PC_INIT, 32'd0, 5'd0};
    localparam logic [MEM_WB_W-1:0]  MEM_WB_RST  = {32'd0, 5'd0, 1'b0};

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stall and flush performance events.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, clear wins over increment, stick at all-ones.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with separate hold/flush controls,
// optional skid slot for a registered in_ready, and stall/flush counters.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both 1. valid never waits on ready; the payload is stable while
// valid is high and not yet accepted. hold masks both in_ready and out_valid
// at the ports; flush masks in_ready only.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] RST_VAL  = {DATA_W{1'b0}},
    parameter bit                SKID     = 1'b0,
    parameter bit                CLR_DATA = 1'b1,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              v_main;
    logic [DATA_W-1:0] d_main;
    logic              v_skid;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = v_main & ~hold;
    assign out_data  = d_main;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    generate
        if (SKID == 1'b0) begin : g_single
            assign v_skid   = 1'b0;
            assign in_ready = ~hold & ~flush & (~v_main | out_ready);

            // Single register: load on accept, otherwise drain on consume.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_main <= 1'b0;
                    d_main <= RST_VAL;
                end else if (flush) begin
                    v_main <= 1'b0;
                    if (CLR_DATA) d_main <= RST_VAL;
                end else if (!hold) begin
                    if (in_xfer) begin
                        v_main <= 1'b1;
                        d_main <= in_data;
                    end else if (out_xfer) begin
                        v_main <= 1'b0;
                    end
                end
            end
        end else begin : g_skid
            logic [DATA_W-1:0] d_skid;
            logic              rdy_q;

            // rdy_q always mirrors ~v_skid but comes straight from a flop.
            assign in_ready = rdy_q & ~hold & ~flush;

            // Main + skid as a two-entry FIFO; skid refills main as it drains.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_main <= 1'b0;
                    d_main <= RST_VAL;
                    v_skid <= 1'b0;
                    d_skid <= RST_VAL;
                    rdy_q  <= 1'b1;
                end else if (flush) begin
                    v_main <= 1'b0;
                    v_skid <= 1'b0;
                    rdy_q  <= 1'b1;
                    if (CLR_DATA) begin
                        d_main <= RST_VAL;
                        d_skid <= RST_VAL;
                    end
                end else if (!hold) begin
                    if (out_xfer || !v_main) begin
                        // Main is free at this edge: oldest beat moves in.
                        if (v_skid) begin
                            v_main <= 1'b1;
                            d_main <= d_skid;
                            v_skid <= 1'b0;
                        end else if (in_xfer) begin
                            v_main <= 1'b1;
                            d_main <= in_data;
                        end else begin
                            v_main <= 1'b0;
                        end
                        rdy_q <= 1'b1;
                    end else if (in_xfer) begin
                        // Main stuck downstream: park the new beat.
                        v_skid <= 1'b1;
                        d_skid <= in_data;
                        rdy_q  <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    logic stall_ev;
    logic flush_ev;

    assign stall_ev = (v_main & ~out_ready) | hold;
    assign flush_ev = flush & (v_main | v_skid);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall_ev),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_ev),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance a is the plain register (SKID=0),
// instance b has the skid slot, a 4-bit counter and a PC_INIT reset payload.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam logic [31:0] B_RST = PC_INIT;

    logic        clk;
    int          total;
    int          bad;

    logic        a_rst, a_flush, a_hold, a_in_valid, a_out_ready;
    logic [31:0] a_in_data;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    logic        b_rst, b_flush, b_hold, b_in_valid, b_out_ready;
    logic [31:0] b_in_data;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    logic [31:0] a_exp_q[$];
    logic [31:0] b_exp_q[$];
    logic [31:0] a_exp_v;
    logic [31:0] b_exp_v;

    logic [10:0] b_or_pat;
    logic [10:0] b_ir_pat;
    int          idx;

    pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .CLR_DATA(1'b1), .CNT_W(16)) dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .flush     (a_flush),
        .hold      (a_hold),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .stall_cnt (a_stall_cnt),
        .flush_cnt (a_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .RST_VAL(B_RST), .SKID(1'b1), .CLR_DATA(1'b1), .CNT_W(4)) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .flush     (b_flush),
        .hold      (b_hold),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .stall_cnt (b_stall_cnt),
        .flush_cnt (b_flush_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push accepted beats, pop on every output transfer.
    always @(negedge clk) begin
        if (a_rst) begin
            a_exp_q.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                total++;
                assert (a_exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL a_out_extra observed=%0h expected=none", a_out_data);
                end
                if (a_exp_q.size() != 0) begin
                    a_exp_v = a_exp_q.pop_front();
                    chk("a_out_order", 64'(a_out_data), 64'(a_exp_v));
                end
            end
            if (a_in_valid && a_in_ready) a_exp_q.push_back(a_in_data);
            if (a_flush) a_exp_q.delete();
        end
        if (b_rst) begin
            b_exp_q.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                total++;
                assert (b_exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL b_out_extra observed=%0h expected=none", b_out_data);
                end
                if (b_exp_q.size() != 0) begin
                    b_exp_v = b_exp_q.pop_front();
                    chk("b_out_order", 64'(b_out_data), 64'(b_exp_v));
                end
            end
            if (b_in_valid && b_in_ready) b_exp_q.push_back(b_in_data);
            if (b_flush) b_exp_q.delete();
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        a_rst = 1'b1; a_flush = 1'b0; a_hold = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_hold = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        b_or_pat = 11'b111_1110_0011;
        b_ir_pat = 11'b111_1100_0111;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;

        // Reset state
        chk("a_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("a_rst_out_data", 64'(a_out_data), 64'd0);
        chk("a_rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("a_rst_stall", 64'(a_stall_cnt), 64'd0);
        chk("a_rst_flush", 64'(a_flush_cnt), 64'd0);
        chk("b_rst_out_valid", 64'(b_out_valid), 64'd0);
        chk("b_rst_out_data", 64'(b_out_data), 64'(B_RST));
        chk("b_rst_in_ready", 64'(b_in_ready), 64'd1);
        chk("b_rst_stall", 64'(b_stall_cnt), 64'd0);

        // SKID=0 stream: 1..8 back to back, each visible one edge later
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data = 32'(i);
            #1;
            chk("a_stream_in_ready", 64'(a_in_ready), 64'd1);
            tick();
            chk("a_stream_out", {31'd0, a_out_valid, a_out_data}, {31'd0, 1'b1, 32'(i)});
        end
        a_in_valid = 1'b0;
        tick();
        chk("a_stream_empty", 64'(a_out_valid), 64'd0);
        chk("a_stream_stall", 64'(a_stall_cnt), 64'd0);

        // SKID=0 hold: 0x55 frozen for two cycles, 0x66 offered but refused
        a_in_valid = 1'b1;
        a_in_data = 32'h55;
        a_out_ready = 1'b0;
        tick();
        a_hold = 1'b1;
        a_in_data = 32'h66;
        a_out_ready = 1'b1;
        #1;
        chk("a_hold_out_valid", 64'(a_out_valid), 64'd0);
        chk("a_hold_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        chk("a_hold_out_valid2", 64'(a_out_valid), 64'd0);
        chk("a_hold_stall1", 64'(a_stall_cnt), 64'd1);
        tick();
        a_hold = 1'b0;
        a_in_valid = 1'b0;
        #1;
        chk("a_hold_release", {31'd0, a_out_valid, a_out_data}, {31'd0, 1'b1, 32'h55});
        chk("a_hold_stall2", 64'(a_stall_cnt), 64'd2);
        tick();
        chk("a_hold_consumed", 64'(a_out_valid), 64'd0);
        chk("a_hold_stall_after", 64'(a_stall_cnt), 64'd2);

        // SKID=0 flush of a full register
        a_in_valid = 1'b1;
        a_in_data = 32'h77;
        a_out_ready = 1'b0;
        tick();
        a_flush = 1'b1;
        a_in_data = 32'h88;
        #1;
        chk("a_flush_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        #1;
        chk("a_flush_out_valid", 64'(a_out_valid), 64'd0);
        chk("a_flush_out_data", 64'(a_out_data), 64'd0);
        chk("a_flush_cnt", 64'(a_flush_cnt), 64'd1);
        chk("a_flush_stall", 64'(a_stall_cnt), 64'd3);

        // SKID=1 backpressure: A0..A5, out_ready low for three cycles
        idx = 0;
        for (int c = 0; c < 11; c++) begin
            b_out_ready = b_or_pat[c];
            b_in_valid = (idx < 6);
            b_in_data = 32'hA0 + 32'(idx);
            #1;
            chk("b_bp_in_ready", 64'(b_in_ready), 64'(b_ir_pat[c]));
            if (b_in_valid && b_in_ready) idx++;
            tick();
        end
        b_in_valid = 1'b0;
        chk("b_bp_accepted", 64'(idx), 64'd6);
        chk("b_bp_drained", 64'(b_exp_q.size()), 64'd0);
        chk("b_bp_stall", 64'(b_stall_cnt), 64'd3);

        // SKID=1 flush with both slots full; 0xEE offered in the flush cycle
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_data = 32'hB0;
        tick();
        b_in_data = 32'hB1;
        tick();
        b_flush = 1'b1;
        b_in_data = 32'hEE;
        #1;
        chk("b_flush_in_ready", 64'(b_in_ready), 64'd0);
        tick();
        b_flush = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("b_flush_out_valid", 64'(b_out_valid), 64'd0);
        chk("b_flush_out_data", 64'(b_out_data), 64'(B_RST));
        chk("b_flush_cnt", 64'(b_flush_cnt), 64'd1);
        chk("b_flush_in_ready_after", 64'(b_in_ready), 64'd1);
        chk("b_flush_stall", 64'(b_stall_cnt), 64'd5);

        // Flush of an empty stage is not counted
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        #1;
        chk("b_flush_empty_cnt", 64'(b_flush_cnt), 64'd1);
        chk("b_flush_empty_valid", 64'(b_out_valid), 64'd0);

        // Reset while both slots are full
        b_in_valid = 1'b1;
        b_in_data = 32'hC0;
        tick();
        b_in_data = 32'hC1;
        tick();
        b_in_valid = 1'b0;
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        #1;
        chk("b_rst2_out_valid", 64'(b_out_valid), 64'd0);
        chk("b_rst2_stall", 64'(b_stall_cnt), 64'd0);
        chk("b_rst2_flush", 64'(b_flush_cnt), 64'd0);
        chk("b_rst2_in_ready", 64'(b_in_ready), 64'd1);
        chk("b_rst2_out_data", 64'(b_out_data), 64'(B_RST));

        // Stall counter saturation at 15 with a 4-bit counter
        b_in_valid = 1'b1;
        b_in_data = 32'hD0;
        tick();
        b_in_valid = 1'b0;
        repeat (10) tick();
        chk("b_sat_mid", 64'(b_stall_cnt), 64'd10);
        repeat (10) tick();
        chk("b_sat_top", 64'(b_stall_cnt), 64'd15);
        b_out_ready = 1'b1;
        tick();
        chk("b_sat_consumed", 64'(b_out_valid), 64'd0);
        chk("b_sat_hold_top", 64'(b_stall_cnt), 64'd15);

        tick();
        chk("a_final_drained", 64'(a_exp_q.size()), 64'd0);
        chk("b_final_drained", 64'(b_exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
